// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the byte-serial memory controller
package mem_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_MEM   = 1'b1
    } req_id_e;

    // Byte count of a MEM-stage access; the unused encoding is treated as a word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            MEM_BYTE: width_bytes = 3'd1;
            MEM_HALF: width_bytes = 3'd2;
            default:  width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates fetch and MEM-stage accesses onto a byte-wide synchronous RAM
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   br,
    input  logic                   if_ce,
    input  logic [INST_ADDR_W-1:0] if_addr,
    output logic                   if_done,
    output logic [INST_W-1:0]      if_rdata,
    input  logic                   mem_re,
    input  logic                   mem_we,
    input  logic [31:0]            mem_addr,
    input  logic [1:0]             mem_width,
    input  logic [31:0]            mem_wdata,
    output logic                   mem_done,
    output logic [31:0]            mem_rdata,
    output logic [ADDR_W-1:0]      ram_a,
    output logic [7:0]             ram_dout,
    output logic                   ram_wr,
    input  logic [7:0]             ram_din
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [2:0]        r_n;
    logic [ADDR_W-1:0] r_base;
    req_id_e           r_id;
    logic              r_is_wr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;

    logic              w_accept;
    req_id_e           w_acc_id;
    logic              w_acc_wr;
    logic [2:0]        w_acc_n;
    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_capture;
    logic              w_fetch_abort;
    logic              w_commit;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_lane;
    logic              w_unused;

    // Pipeline address bits above the RAM window are deliberately dropped.
    assign w_unused = ^{if_addr[INST_ADDR_W-1:ADDR_W], mem_addr[31:ADDR_W]};

    assign w_addr        = r_base + ADDR_W'(r_cnt);
    assign w_lane        = 2'(r_cnt - 3'd1);
    assign w_fetch_abort = br && (r_id == REQ_FETCH) &&
                           ((r_state == ST_READ) || (r_state == ST_DONE));
    assign w_commit      = (r_state == ST_DONE) && !w_fetch_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_acc_id    = REQ_FETCH;
        w_acc_wr    = 1'b0;
        w_acc_n     = 3'd4;
        w_acc_addr  = if_addr[ADDR_W-1:0];
        w_capture   = 1'b0;
        ram_a       = '0;
        ram_dout    = 8'h00;
        ram_wr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_we) begin
                    w_accept    = 1'b1;
                    w_acc_id    = REQ_MEM;
                    w_acc_wr    = 1'b1;
                    w_acc_n     = width_bytes(mem_width);
                    w_acc_addr  = mem_addr[ADDR_W-1:0];
                    w_state_nxt = ST_WRITE;
                end else if (mem_re) begin
                    w_accept    = 1'b1;
                    w_acc_id    = REQ_MEM;
                    w_acc_n     = width_bytes(mem_width);
                    w_acc_addr  = mem_addr[ADDR_W-1:0];
                    w_state_nxt = ST_READ;
                end else if (if_ce) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_fetch_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    // Address phase runs one cycle ahead of the data capture.
                    if (r_cnt < r_n) begin
                        ram_a = w_addr;
                    end
                    w_capture = (r_cnt != 3'd0);
                    if (r_cnt == r_n) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                ram_wr   = 1'b1;
                ram_a    = w_addr;
                ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                if (r_cnt == r_n - 3'd1) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n         <= 3'd0;
            r_base      <= '0;
            r_id        <= REQ_FETCH;
            r_is_wr     <= 1'b0;
            r_wdata     <= 32'h0;
            r_data      <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_mem_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_base  <= w_acc_addr;
                r_n     <= w_acc_n;
                r_id    <= w_acc_id;
                r_is_wr <= w_acc_wr;
                r_wdata <= mem_wdata;
                r_data  <= 32'h0;
            end
            if (w_capture) begin
                r_data[{w_lane, 3'b000} +: 8] <= ram_din;
            end
            if (if_done) begin
                r_if_rdata <= r_data;
            end
            if (mem_done && !r_is_wr) begin
                r_mem_rdata <= r_data;
            end
        end
    end

    // The assembled word is visible during DONE and retained afterwards.
    assign if_done   = w_commit && (r_id == REQ_FETCH);
    assign mem_done  = w_commit && (r_id == REQ_MEM);
    assign if_rdata  = if_done ? r_data : r_if_rdata;
    assign mem_rdata = (mem_done && !r_is_wr) ? r_data : r_mem_rdata;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the pipeline and the single-port, byte-wide synchronous RAM. It serves two requesters: instruction fetch (word reads on behalf of the IF stage) and the MEM stage (byte/half/word loads and stores). Each 32-bit access is serialised into byte transfers, and completion is signalled with a one-cycle done pulse. The MEM stage has priority over fetch, and a taken branch aborts an in-flight fetch.

## Interface
Parameters:
- ADDR_W, 17, RAM address width; upper pipeline address bits are ignored.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous reset, active-low
- br  in  1  taken branch; aborts an in-flight fetch
- if_ce  in  1  fetch request (level, held until if_done)
- if_addr  in  32  fetch address (`InstAddrBus`)
- if_done  out  1  one-cycle pulse; fetch word valid on if_rdata
- if_rdata  out  32  fetched instruction (`InstBus`), little-endian
- mem_re  in  1  load request (level)
- mem_we  in  1  store request (level)
- mem_addr  in  32  load/store address
- mem_width  in  2  access width: `MemByte` 00, `MemHalf` 01, `MemWord` 10
- mem_wdata  in  32  store data; low bytes used for narrower widths
- mem_done  out  1  one-cycle pulse; load/store complete
- mem_rdata  out  32  load data, zero-extended; MEM stage sign-extends
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write data
- ram_wr  out  1  RAM write enable
- ram_din  in  8  RAM read data; 1-cycle latency after ram_a

## Operation
- States:
  - IDLE: samples requests.
  - READ: byte counter cnt runs 0..N.
  - WRITE: cnt runs 0..N-1.
  - DONE: drives the done pulse for one cycle.
- Latched at accept: base address, N (1, 2 or 4 from the width; fetch is always 4), requester ID, wdata.
- Arbitration in IDLE, highest first: mem_we, then mem_re, then if_ce.
  - mem_we and mem_re both high is treated as a store.
  - Requests are ignored in READ, WRITE and DONE.
- READ:
  - For cnt<N: ram_a = base+cnt.
  - For cnt>=1: ram_din is captured into byte lane cnt-1 of the data register.
  - At cnt==N: go to DONE.
- WRITE:
  - ram_wr=1, ram_a = base+cnt, ram_dout = wdata byte cnt.
  - At cnt==N-1: go to DONE.
- DONE:
  - Pulse if_done or mem_done according to the requester ID.
  - The matching rdata port holds the assembled word; unread upper bytes are 0.
  - Next state is IDLE.
- Address arithmetic: base+cnt is computed in ADDR_W bits and wraps modulo 2^ADDR_W. Misaligned accesses are legal.
- Branch abort:
  - br high during READ or DONE owned by fetch: go to IDLE, no if_done.
  - The aborted fetch's if_rdata is not updated.
  - br does not affect MEM-stage accesses.
- A requester that drops its request mid-access does not abort it (except the br case); done still pulses.
- if_rdata and mem_rdata hold their last value between accesses.

## Timing
- Reset: state IDLE, cnt 0, all outputs 0 (if_done, mem_done, ram_wr, ram_a, ram_dout, if_rdata, mem_rdata). Reset asserted mid-write drops ram_wr immediately.
- Request sampled in cycle T (IDLE). ram_a issues in T+1..T+N.
- Done cycle:
  - Word read: done in T+6. Half read: T+4. Byte read: T+3.
  - Word write: done in T+5. Byte write: T+2.
- Done is high exactly one cycle. The controller is back in IDLE in the following cycle.
- Back-to-back: a request held through DONE is re-accepted in the IDLE cycle after it. The minimum gap between word fetches is 7 cycles.
- ram_wr is high only in WRITE cycles and is never high together with a read address phase.

## Structure
- defines.v holds: `InstAddrBus`, `InstBus`, `MemByte`/`MemHalf`/`MemWord`, state encodings, and requester IDs.
- Single module with no sub-module. The byte-lane assembler is an indexed register write inside the FSM.

## Test plan
- Reset, then if_ce=1, if_addr=0x0 over RAM bytes 13,00,50,00 -> if_done in T+6, if_rdata=0x00500013, ram_a 0..3.
- mem_re=1, width `MemByte`, addr 0x5 over byte 0xF0, with if_ce=1 concurrently -> mem_done in T+3, mem_rdata=0x000000F0. The fetch starts afterwards and its if_done arrives 7 cycles after mem_done.
- mem_we=1, width `MemHalf`, addr 0x1FFFF, wdata 0xAABBCCDD -> ram_wr 2 cycles writing 0xDD@0x1FFFF then 0xCC@0x00000 (wrap), mem_done in T+3.
- Fetch in progress, br=1 at cnt 2 -> no if_done. Next if_addr=0x40 is accepted the following cycle and completes normally.
- mem_re and mem_we both high -> store performed, no read phase, one mem_done.
- rst pulsed low during a word write at cnt 1 -> ram_wr low immediately, no done, FSM in IDLE after release.
